// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-requester arbiter for the single register-file
// write port. Requester 0 (pipeline writeback) has fixed priority over
// requester 1 (multi-cycle unit). The grant is combinational and the chosen
// write is registered onto we/waddr/wdata one cycle later. A write to r0 is
// consumed but never enabled.
//
// Build option WB_ARB_STARVE_EN: when defined, a starvation guard forces one
// grant to requester 1 after STARVE_LIMIT consecutive denied cycles, and
// raises stall0 while requester 0 is held off. When undefined, arbitration is
// strict priority, stall0 is tied low and STARVE_LIMIT has no effect.
module regfile_wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [4:0]  addr0,
   input  logic [31:0] data0,
   output logic        gnt0,
   input  logic        req1,
   input  logic [4:0]  addr1,
   input  logic [31:0] data1,
   output logic        gnt1,
   output logic        we,
   output logic [4:0]  waddr,
   output logic [31:0] wdata,
   output logic        stall0
);

   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_stall0;
   logic        w_wr;
   logic [4:0]  w_addr;
   logic [31:0] w_data;

   logic        r_we;
   logic [4:0]  r_waddr;
   logic [31:0] r_wdata;

`ifdef WB_ARB_STARVE_EN
   // Limit clamped into the 4-bit counter range (1..15).
   localparam logic [4:0] LP_LIMIT =
      (STARVE_LIMIT < 1)  ? 5'd1  :
      (STARVE_LIMIT > 15) ? 5'd15 : 5'(STARVE_LIMIT);

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_FORCE1 = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic [4:0] w_cnt_inc;

   assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;

   // Arbiter state and starve counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_NORMAL;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Grant decode and next-state; a forced slot lasts exactly one cycle
   // whether or not requester 1 is still asking.
   always_comb begin
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_stall0    = 1'b0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_NORMAL: begin
            if (req0)      w_gnt0 = 1'b1;
            else if (req1) w_gnt1 = 1'b1;
            if (req1 && !w_gnt1) begin
               if (w_cnt_inc >= LP_LIMIT) begin
                  w_state_nxt = ST_FORCE1;
                  w_cnt_nxt   = 4'd0;
               end else begin
                  w_cnt_nxt   = w_cnt_inc[3:0];
               end
            end else begin
               w_cnt_nxt = 4'd0;
            end
         end
         ST_FORCE1: begin
            w_gnt1      = req1;
            w_stall0    = req0;
            w_state_nxt = ST_NORMAL;
            w_cnt_nxt   = 4'd0;
         end
         default: begin
            w_state_nxt = ST_NORMAL;
            w_cnt_nxt   = 4'd0;
         end
      endcase
      // No grants are visible while reset is held.
      if (!rst) begin
         w_gnt0   = 1'b0;
         w_gnt1   = 1'b0;
         w_stall0 = 1'b0;
      end
   end
`else
   // STARVE_LIMIT has no effect in the strict-priority build.
   if (STARVE_LIMIT > 15) begin : g_starve_limit_ignored
   end

   // Strict priority: requester 0 always wins; nothing granted in reset.
   always_comb begin
      w_gnt0   = req0 & rst;
      w_gnt1   = req1 & ~req0 & rst;
      w_stall0 = 1'b0;
   end
`endif

   assign w_wr   = w_gnt0 | w_gnt1;
   assign w_addr = w_gnt1 ? addr1 : addr0;
   assign w_data = w_gnt1 ? data1 : data0;

   // Register the granted write; r0 writes are swallowed, address/data hold
   // when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we    <= 1'b0;
         r_waddr <= 5'd0;
         r_wdata <= 32'd0;
      end else begin
         r_we <= w_wr && (w_addr != 5'd0);
         if (w_wr) begin
            r_waddr <= w_addr;
            r_wdata <= w_data;
         end
      end
   end

   assign gnt0   = w_gnt0;
   assign gnt1   = w_gnt1;
   assign stall0 = w_stall0;
   assign we     = r_we;
   assign waddr  = r_waddr;
   assign wdata  = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vectors with literal expectations
// plus a cycle-by-cycle behavioural model checked on every falling edge.
module tb_regfile_wb_arbiter;
   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [4:0]  addr0, addr1;
   logic [31:0] data0, data1;
   logic        gnt0, gnt1, we, stall0;
   logic [4:0]  waddr;
   logic [31:0] wdata;

   int vec = 0;
   int mis = 0;

   regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
      .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
      .we(we), .waddr(waddr), .wdata(wdata), .stall0(stall0)
   );

   always #5 clk = ~clk;

`ifdef WB_ARB_STARVE_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end
   endtask

   // Model: what the write port must show, and how long requester 1 has
   // gone unserved while asking.
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   int          m_denied;
   bit          m_owed;

   always @(negedge clk) begin
      logic e0, e1, es;
      if (!rst) begin
         m_we = 0; m_waddr = 0; m_wdata = 0; m_denied = 0; m_owed = 0;
         chk("rst_gnt0", 32'(gnt0), 0);
         chk("rst_gnt1", 32'(gnt1), 0);
         chk("rst_stall0", 32'(stall0), 0);
         chk("rst_we", 32'(we), 0);
         chk("rst_waddr", 32'(waddr), 0);
         chk("rst_wdata", wdata, 0);
      end else begin
         chk("m_we", 32'(we), 32'(m_we));
         chk("m_waddr", 32'(waddr), 32'(m_waddr));
         chk("m_wdata", wdata, m_wdata);
         if (m_owed) begin
            e0 = 0; e1 = req1; es = req0;
         end else begin
            e0 = req0; e1 = req1 && !req0; es = 0;
         end
         chk("m_gnt0", 32'(gnt0), 32'(e0));
         chk("m_gnt1", 32'(gnt1), 32'(e1));
         chk("m_stall0", 32'(stall0), 32'(es));
         // next-cycle write port
         m_we = 0;
         if (e0 || e1) begin
            m_waddr = e1 ? addr1 : addr0;
            m_wdata = e1 ? data1 : data0;
            m_we    = (m_waddr != 0);
         end
         // starvation bookkeeping: an owed slot is spent whatever happens
         if (m_owed) begin
            m_owed = 0; m_denied = 0;
         end else if (req1 && !e1) begin
            m_denied++;
            if (GUARD && m_denied == LIM) begin
               m_owed = 1; m_denied = 0;
            end
         end else begin
            m_denied = 0;
         end
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic idle;
      req0 = 0; req1 = 0;
   endtask

   // req0 and req1 held together; the forced grant must land on cycle LIM+1.
   task automatic starve_run(input string tag);
      req0 = 1; addr0 = 5'd2; data0 = 32'h0000_0002;
      req1 = 1; addr1 = 5'd6; data1 = 32'h0000_0006;
      for (int c = 1; c <= LIM + 1; c++) begin
         @(negedge clk);
         if (GUARD && c == LIM + 1) begin
            chk({tag, "_force_gnt1"}, 32'(gnt1), 1);
            chk({tag, "_force_stall0"}, 32'(stall0), 1);
            chk({tag, "_force_gnt0"}, 32'(gnt0), 0);
         end else begin
            chk({tag, "_gnt0"}, 32'(gnt0), 1);
            chk({tag, "_gnt1"}, 32'(gnt1), 0);
         end
         tick();
      end
      req1 = 0;
      @(negedge clk);
      chk({tag, "_resume_gnt0"}, 32'(gnt0), 1);
      chk({tag, "_resume_stall0"}, 32'(stall0), 0);
      tick();
      idle();
      tick();
   endtask

   typedef struct {
      logic r0, r1;
      logic [4:0] a0, a1;
      logic [31:0] d0, d1;
   } vec_t;

   vec_t tbl[8];

   initial begin
      rst = 0; idle();
      addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
      m_we = 0; m_waddr = 0; m_wdata = 0; m_denied = 0; m_owed = 0;
      #2; req0 = 1; req1 = 1;
      #1;
      chk("lit_rst_gnt0", 32'(gnt0), 0);
      chk("lit_rst_gnt1", 32'(gnt1), 0);
      chk("lit_rst_we", 32'(we), 0);
      chk("lit_rst_wdata", wdata, 0);
      idle();
      #20 rst = 1;
      tick();

      // single writeback
      req0 = 1; addr0 = 5'd5; data0 = 32'h1234_5678;
      @(negedge clk);
      chk("lit_t1_gnt0", 32'(gnt0), 1);
      chk("lit_t1_gnt1", 32'(gnt1), 0);
      tick(); idle();
      chk("lit_t1_we", 32'(we), 1);
      chk("lit_t1_waddr", 32'(waddr), 5);
      chk("lit_t1_wdata", wdata, 32'h1234_5678);
      tick();
      chk("lit_t1_we_off", 32'(we), 0);
      chk("lit_t1_waddr_hold", 32'(waddr), 5);

      // collision, then requester 1 alone
      req0 = 1; addr0 = 5'd3; data0 = 32'h0000_00A3;
      req1 = 1; addr1 = 5'd4; data1 = 32'h0000_00B4;
      @(negedge clk);
      chk("lit_t2_gnt0", 32'(gnt0), 1);
      chk("lit_t2_gnt1", 32'(gnt1), 0);
      tick(); req0 = 0;
      chk("lit_t2_waddr3", 32'(waddr), 3);
      @(negedge clk);
      chk("lit_t2_gnt1b", 32'(gnt1), 1);
      tick(); idle();
      chk("lit_t2_we4", 32'(we), 1);
      chk("lit_t2_waddr4", 32'(waddr), 4);
      chk("lit_t2_wdata4", wdata, 32'h0000_00B4);
      tick();

      // write to r0 is consumed without enable
      req1 = 1; addr1 = 5'd0; data1 = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("lit_t3_gnt1", 32'(gnt1), 1);
      tick(); idle();
      chk("lit_t3_we", 32'(we), 0);
      chk("lit_t3_wdata", wdata, 32'hFFFF_FFFF);
      tick();

      // starvation guard
      starve_run("t4");

      // forced slot with requester 1 withdrawn
      req0 = 1; addr0 = 5'd2; data0 = 32'h2;
      req1 = 1; addr1 = 5'd6; data1 = 32'h6;
      for (int c = 0; c < LIM; c++) tick();
      req1 = 0;
      @(negedge clk);
      chk("lit_t5_gnt0", 32'(gnt0), GUARD ? 0 : 1);
      chk("lit_t5_gnt1", 32'(gnt1), 0);
      chk("lit_t5_stall0", 32'(stall0), GUARD ? 1 : 0);
      tick();
      chk("lit_t5_we", 32'(we), GUARD ? 0 : 1);
      idle(); tick();
      // counter must be clear: a fresh run forces on the same cycle again
      starve_run("t5b");

      // identical addresses serialise
      req0 = 1; addr0 = 5'd9; data0 = 32'h11;
      req1 = 1; addr1 = 5'd9; data1 = 32'h22;
      tick(); req0 = 0;
      chk("lit_t6_first", wdata, 32'h11);
      tick(); idle();
      chk("lit_t6_second", wdata, 32'h22);
      chk("lit_t6_waddr", 32'(waddr), 9);
      tick();

      // async reset one cycle after a grant
      req0 = 1; addr0 = 5'd7; data0 = 32'hDEAD_BEEF;
      tick(); idle();
      chk("lit_t7_we_pre", 32'(we), 1);
      #2 rst = 0;
      #1;
      chk("lit_t7_we", 32'(we), 0);
      chk("lit_t7_waddr", 32'(waddr), 0);
      chk("lit_t7_wdata", wdata, 0);
      tick(); #2 rst = 1;
      tick();
      req0 = 1; addr0 = 5'd12; data0 = 32'h77;
      tick(); idle();
      chk("lit_t7_after_we", 32'(we), 1);
      chk("lit_t7_after_waddr", 32'(waddr), 12);
      chk("lit_t7_after_wdata", wdata, 32'h77);
      tick();

      // mixed vectors, checked by the model only
      tbl[0] = '{1, 0, 5'd1, 5'd0, 32'hA1, 32'h0};
      tbl[1] = '{0, 1, 5'd0, 5'd2, 32'h0, 32'hB2};
      tbl[2] = '{1, 1, 5'd3, 5'd4, 32'hA3, 32'hB4};
      tbl[3] = '{0, 1, 5'd0, 5'd4, 32'h0, 32'hB4};
      tbl[4] = '{0, 0, 5'd8, 5'd8, 32'h5, 32'h6};
      tbl[5] = '{1, 0, 5'd0, 5'd0, 32'hC0, 32'h0};
      tbl[6] = '{1, 1, 5'd31, 5'd30, 32'hF1, 32'hF0};
      tbl[7] = '{0, 1, 5'd31, 5'd30, 32'hF1, 32'hF0};
      for (int i = 0; i < 8; i++) begin
         req0 = tbl[i].r0; req1 = tbl[i].r1;
         addr0 = tbl[i].a0; addr1 = tbl[i].a1;
         data0 = tbl[i].d0; data1 = tbl[i].d1;
         tick();
      end
      idle();
      tick(); tick();
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end
endmodule
